// File: rtl/apb_slave_responder.sv
// ---------------------------------------------------------------------------
// apb_slave_responder
//
// APB completer on the peripheral side of the AHB-to-APB bridge. It answers
// transfers from its own bit of Pselx and holds a DEPTH-word 32-bit register
// file. Every access phase gets a fixed number of wait states. Out-of-range
// and misaligned accesses complete with Pslverr. Completed transfers are
// counted, and APB protocol violations are latched in a sticky flag.
//
// Ports:
//   Hclk          clock, all logic on the rising edge
//   Hreset        synchronous, active-high reset
//   Pselx[2:0]    one-hot peripheral select; only bit SLV_ID is decoded
//   Penable       access-phase strobe
//   Pwrite        1 = write, 0 = read
//   Paddr[31:0]   byte address
//   Pwdata[31:0]  write data
//   Prdata[31:0]  read data; held through the whole access phase
//   Pready        transfer completes this cycle
//   Pslverr       error response, qualified by Pready
//   wr_count      successful writes completed (wraps)
//   rd_count      successful reads completed (wraps)
//   protocol_err  sticky protocol-violation flag, cleared only by reset
// ---------------------------------------------------------------------------
module apb_slave_responder #(
  parameter int          SLV_ID      = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH       = 16,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic [2:0]  Pselx,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready,
  output logic        Pslverr,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic        protocol_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
  localparam logic [3:0]  WAIT_LIM = 4'(WAIT_CYCLES);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t          state_r;
  logic [3:0]      wcnt_r;
  logic            wr_r;
  logic            err_r;
  logic [AW-1:0]   idx_r;
  logic [31:0]     wdata_r;
  logic [31:0]     prdata_r;
  logic [15:0]     wr_count_r;
  logic [15:0]     rd_count_r;
  logic            protocol_err_r;
  logic [31:0]     mem_r [DEPTH];

  logic            sel_s;
  logic [31:0]     off_s;
  logic            err_s;
  logic [AW-1:0]   idx_s;
  logic            ready_s;
  logic [31:0]     setup_rdata_s;
  logic            unused_sel_bits_s;

  // Address decode of the current bus request and ready decode of held state.
  always_comb begin
    sel_s   = Pselx[SLV_ID];
    off_s   = Paddr - BASE_ADDR;
    err_s   = (off_s[1:0] != 2'b00) || (off_s >= SPAN);
    idx_s   = off_s[AW+1:2];
    // Ready depends only on registers so it is glitch-free toward the bridge.
    ready_s = (state_r == ST_ACCESS) && (wcnt_r == WAIT_LIM);
    if (!Pwrite && !err_s) begin
      setup_rdata_s = mem_r[idx_s];
    end else begin
      setup_rdata_s = 32'h0000_0000;
    end
  end

  // Non-selected Pselx bits are intentionally ignored.
  assign unused_sel_bits_s = ^Pselx;

  assign Prdata       = prdata_r;
  assign Pready       = ready_s;
  assign Pslverr      = ready_s & err_r;
  assign wr_count     = wr_count_r;
  assign rd_count     = rd_count_r;
  assign protocol_err = protocol_err_r;

  // Transfer FSM, request latch, register file and counters.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_r        <= ST_IDLE;
      wcnt_r         <= 4'd0;
      wr_r           <= 1'b0;
      err_r          <= 1'b0;
      idx_r          <= '0;
      wdata_r        <= 32'h0000_0000;
      prdata_r       <= 32'h0000_0000;
      wr_count_r     <= 16'd0;
      rd_count_r     <= 16'd0;
      protocol_err_r <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (sel_s && !Penable) begin
            // Setup phase: capture the request; read data is fetched now so
            // it is stable for the whole access phase.
            wr_r     <= Pwrite;
            err_r    <= err_s;
            idx_r    <= idx_s;
            wdata_r  <= Pwdata;
            wcnt_r   <= 4'd0;
            prdata_r <= setup_rdata_s;
            state_r  <= ST_ACCESS;
          end else if (sel_s && Penable) begin
            // Access phase without a preceding setup: flag, do not respond.
            protocol_err_r <= 1'b1;
            prdata_r       <= 32'h0000_0000;
          end else begin
            prdata_r <= 32'h0000_0000;
          end
        end
        ST_ACCESS: begin
          if (!sel_s) begin
            // Select dropped mid-transfer: abort without side effects.
            protocol_err_r <= 1'b1;
            prdata_r       <= 32'h0000_0000;
            state_r        <= ST_IDLE;
          end else if (!Penable) begin
            // A new setup while a transfer is open: flag and restart.
            protocol_err_r <= 1'b1;
            wr_r           <= Pwrite;
            err_r          <= err_s;
            idx_r          <= idx_s;
            wdata_r        <= Pwdata;
            wcnt_r         <= 4'd0;
            prdata_r       <= setup_rdata_s;
          end else if (!ready_s) begin
            wcnt_r <= wcnt_r + 4'd1;
          end else begin
            // Completion edge: commit the write before any following setup.
            if (!err_r) begin
              if (wr_r) begin
                mem_r[idx_r] <= wdata_r;
                wr_count_r   <= wr_count_r + 16'd1;
              end else begin
                rd_count_r   <= rd_count_r + 16'd1;
              end
            end else begin
              wr_count_r <= wr_count_r;
            end
            prdata_r <= 32'h0000_0000;
            state_r  <= ST_IDLE;
          end
        end
        default: begin
          prdata_r <= 32'h0000_0000;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_slave_responder.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_responder
//
// Directed bench for apb_slave_responder. Instance A has no wait states,
// instance B has three. Both share the bus data/control lines but each has
// its own Pselx, so only the addressed instance sees a transfer.
// ---------------------------------------------------------------------------
module tb_apb_slave_responder;

  logic        Hclk;
  logic        Hreset;
  logic [2:0]  pselx_a;
  logic [2:0]  pselx_b;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  logic [31:0] a_prdata, b_prdata;
  logic        a_pready, b_pready;
  logic        a_pslverr, b_pslverr;
  logic [15:0] a_wr, b_wr, a_rd, b_rd;
  logic        a_perr, b_perr;

  int checks = 0;
  int errors = 0;

  apb_slave_responder #(.SLV_ID(0), .BASE_ADDR(32'h8000_0000), .DEPTH(16), .WAIT_CYCLES(0)) u_dut_a (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(pselx_a), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(a_prdata), .Pready(a_pready), .Pslverr(a_pslverr),
    .wr_count(a_wr), .rd_count(a_rd), .protocol_err(a_perr)
  );

  apb_slave_responder #(.SLV_ID(0), .BASE_ADDR(32'h8000_0000), .DEPTH(16), .WAIT_CYCLES(3)) u_dut_b (
    .Hclk(Hclk), .Hreset(Hreset), .Pselx(pselx_b), .Penable(Penable), .Pwrite(Pwrite),
    .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(b_prdata), .Pready(b_pready), .Pslverr(b_pslverr),
    .wr_count(b_wr), .rd_count(b_rd), .protocol_err(b_perr)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transfer. Address/data are perturbed during wait states to
  // show the latched request is what gets used.
  task automatic xfer(input bit use_b, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, output logic [31:0] rdata,
                      output logic err, output int nwait, output bit stable);
    logic [31:0] first_rd;
    logic [31:0] rd_now;
    logic        rdy;
    bit          done;
    Pwrite  = wr;
    Paddr   = addr;
    Pwdata  = data;
    Penable = 1'b0;
    if (use_b) pselx_b = 3'b001; else pselx_a = 3'b001;
    tick();
    Penable  = 1'b1;
    nwait    = 0;
    stable   = 1'b1;
    done     = 1'b0;
    rdata    = 32'h0;
    err      = 1'b0;
    first_rd = 32'h0;
    for (int c = 0; c < 40 && !done; c++) begin
      rd_now = use_b ? b_prdata : a_prdata;
      rdy    = use_b ? b_pready : a_pready;
      if (c == 0) first_rd = rd_now;
      else if (rd_now !== first_rd) stable = 1'b0;
      if (rdy) begin
        rdata = rd_now;
        err   = use_b ? b_pslverr : a_pslverr;
        done  = 1'b1;
      end else begin
        nwait++;
        Pwdata = ~data;
        Paddr  = addr ^ 32'h0000_0004;
      end
      tick();
    end
    Penable = 1'b0;
    pselx_a = 3'b000;
    pselx_b = 3'b000;
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  int          nw;
  bit          st;

  initial begin
    Hreset = 1'b1; pselx_a = 3'b000; pselx_b = 3'b000;
    Penable = 1'b0; Pwrite = 1'b0; Paddr = 32'h0; Pwdata = 32'h0;
    tick(); tick();
    Hreset = 1'b0;

    // Reset state
    check("rst_prdata", a_prdata, 32'h0);
    check("rst_pready", {31'd0, a_pready}, 32'd0);
    check("rst_pslverr", {31'd0, a_pslverr}, 32'd0);
    check("rst_wr", {16'd0, a_wr}, 32'd0);
    check("rst_rd", {16'd0, a_rd}, 32'd0);
    check("rst_perr", {31'd0, a_perr}, 32'd0);

    // A: write then back-to-back read, zero wait states
    xfer(1'b0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, rd, er, nw, st);
    check("a_wr_nwait", nw, 32'd0);
    check("a_wr_err", {31'd0, er}, 32'd0);
    xfer(1'b0, 1'b0, 32'h8000_0008, 32'h0, rd, er, nw, st);
    check("a_rd_nwait", nw, 32'd0);
    check("a_rd_data", rd, 32'hDEAD_BEEF);
    check("a_rd_err", {31'd0, er}, 32'd0);
    check("a_wr_count1", {16'd0, a_wr}, 32'd1);
    check("a_rd_count1", {16'd0, a_rd}, 32'd1);
    check("a_perr0", {31'd0, a_perr}, 32'd0);

    // B: three wait states, data stable across the whole access phase
    xfer(1'b1, 1'b1, 32'h8000_0004, 32'h1234_5678, rd, er, nw, st);
    check("b_wr_nwait", nw, 32'd3);
    xfer(1'b1, 1'b0, 32'h8000_0004, 32'h0, rd, er, nw, st);
    check("b_rd_nwait", nw, 32'd3);
    check("b_rd_data", rd, 32'h1234_5678);
    check("b_rd_stable", {31'd0, st}, 32'd1);
    check("b_counts", {b_wr, b_rd}, {16'd1, 16'd1});

    // A: out-of-range write and misaligned read
    xfer(1'b0, 1'b1, 32'h8000_0040, 32'hCAFE_F00D, rd, er, nw, st);
    check("a_oor_err", {31'd0, er}, 32'd1);
    xfer(1'b0, 1'b0, 32'h8000_0002, 32'h0, rd, er, nw, st);
    check("a_mis_err", {31'd0, er}, 32'd1);
    check("a_mis_data", rd, 32'h0);
    check("a_err_counts", {a_wr, a_rd}, {16'd1, 16'd1});
    xfer(1'b0, 1'b0, 32'h8000_0000, 32'h0, rd, er, nw, st);
    check("a_word0_untouched", rd, 32'h0);
    xfer(1'b0, 1'b0, 32'h8000_0008, 32'h0, rd, er, nw, st);
    check("a_word2_kept", rd, 32'hDEAD_BEEF);
    check("a_counts3", {a_wr, a_rd}, {16'd1, 16'd3});

    // B: select dropped in the second wait state of a write
    check("b_perr_pre", {31'd0, b_perr}, 32'd0);
    Pwrite = 1'b1; Paddr = 32'h8000_0004; Pwdata = 32'hAAAA_5555;
    Penable = 1'b0; pselx_b = 3'b001;
    tick();
    Penable = 1'b1;
    tick();
    check("b_abort_wait", {31'd0, b_pready}, 32'd0);
    pselx_b = 3'b000; Penable = 1'b0;
    tick();
    check("b_abort_pready", {31'd0, b_pready}, 32'd0);
    check("b_abort_perr", {31'd0, b_perr}, 32'd1);
    check("b_abort_wr", {16'd0, b_wr}, 32'd1);
    xfer(1'b1, 1'b0, 32'h8000_0004, 32'h0, rd, er, nw, st);
    check("b_after_abort_data", rd, 32'h1234_5678);
    check("b_after_abort_nwait", nw, 32'd3);
    check("b_after_abort_rd", {16'd0, b_rd}, 32'd2);

    // A: another slave's select bit must be ignored
    Pwrite = 1'b1; Paddr = 32'h8000_0000; Pwdata = 32'hFFFF_FFFF;
    Penable = 1'b0; pselx_a = 3'b010;
    tick();
    check("a_othersel_setup", {31'd0, a_pready}, 32'd0);
    Penable = 1'b1;
    tick();
    check("a_othersel_access", {31'd0, a_pready}, 32'd0);
    Penable = 1'b0; pselx_a = 3'b000;
    xfer(1'b0, 1'b0, 32'h8000_0000, 32'h0, rd, er, nw, st);
    check("a_othersel_word0", rd, 32'h0);
    check("a_othersel_perr", {31'd0, a_perr}, 32'd0);
    check("a_othersel_wr", {16'd0, a_wr}, 32'd1);

    // A: access phase without setup
    pselx_a = 3'b001; Penable = 1'b1; Pwrite = 1'b0;
    tick();
    check("a_nosetup_pready", {31'd0, a_pready}, 32'd0);
    check("a_nosetup_perr", {31'd0, a_perr}, 32'd1);
    pselx_a = 3'b000; Penable = 1'b0;

    // B: reset in the middle of a write access
    Pwrite = 1'b1; Paddr = 32'h8000_0008; Pwdata = 32'h55AA_55AA;
    Penable = 1'b0; pselx_b = 3'b001;
    tick();
    Penable = 1'b1;
    tick();
    Hreset = 1'b1;
    tick();
    Hreset = 1'b0; pselx_b = 3'b000; Penable = 1'b0;
    check("b_rst_prdata", b_prdata, 32'h0);
    check("b_rst_flags", {29'd0, b_pready, b_pslverr, b_perr}, 32'd0);
    check("b_rst_counts", {b_wr, b_rd}, 32'd0);
    check("a_rst_counts", {a_wr, a_rd}, 32'd0);
    xfer(1'b1, 1'b0, 32'h8000_0004, 32'h0, rd, er, nw, st);
    check("b_rst_word1", rd, 32'h0);
    xfer(1'b1, 1'b0, 32'h8000_0008, 32'h0, rd, er, nw, st);
    check("b_rst_word2", rd, 32'h0);

    // A: a run of 20 writes wrapping over all 16 words
    for (int i = 0; i < 20; i++) begin
      xfer(1'b0, 1'b1, 32'h8000_0000 + 32'((i % 16) * 4), 32'hC0DE_0000 + 32'(i), rd, er, nw, st);
    end
    check("a_run_wr", {16'd0, a_wr}, 32'd20);
    xfer(1'b0, 1'b0, 32'h8000_000C, 32'h0, rd, er, nw, st);
    check("a_run_word3", rd, 32'hC0DE_0013);
    xfer(1'b0, 1'b0, 32'h8000_0014, 32'h0, rd, er, nw, st);
    check("a_run_word5", rd, 32'hC0DE_0005);
    check("a_run_rd", {16'd0, a_rd}, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
